// File: rtl/io_handshake_port_pkg.sv
// Shared definitions for the processor-side handshake port: FSM encoding and
// transfer direction constants.
package io_handshake_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK  = 2'b01,
        REL  = 2'b10
    } hs_state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/io_handshake_port_byte_fifo.sv
// Small register-based FIFO with combinational head output; entries are reset
// so a freshly cleared FIFO presents zero on rdata.
module byte_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         wdata,
    output logic [width-1:0]         rdata,
    output logic [$clog2(depth):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem_reg [depth];
    logic [aw-1:0]    wr_ptr_reg;
    logic [aw-1:0]    rd_ptr_reg;
    logic [aw:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && wr_ptr_reg == aw'(gi)) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == (aw + 1)'(depth));

endmodule

// File: rtl/io_handshake_port.sv
// Byte-wide I/O port: four-phase request/acknowledge toward the processor,
// valid/ready toward the external device, with an RX and a TX FIFO between.
module io_handshake_port
    import io_handshake_port_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             p_hs_out,
    input  logic             p_wr_nrd,
    input  logic [width-1:0] p_bus_out,
    output logic [width-1:0] p_bus_in,
    output logic             p_hs_in,
    input  logic [width-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [width-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             rx_empty,
    output logic             tx_full
);

    localparam int cw = $clog2(depth) + 1;

    hs_state_t        state_reg, state_next;
    logic             dir_reg, dir_next;
    logic [width-1:0] bus_in_reg;

    logic             tx_push, rx_pop, load_bus;
    logic [width-1:0] rx_head;
    logic [cw-1:0]    rx_count, tx_count;
    logic             rx_empty_int, rx_full_int;
    logic             tx_empty_int, tx_full_int;
    logic             rx_avail, tx_room;

    assign rx_avail = (rx_count != '0);
    assign tx_room  = (tx_count < cw'(depth));

    byte_fifo #(.width(width), .depth(depth)) u_rx_fifo (
        .clk   (g_clk),
        .rst   (g_clr),
        .push  (rx_valid & ~rx_full_int),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .count (rx_count),
        .empty (rx_empty_int),
        .full  (rx_full_int)
    );

    byte_fifo #(.width(width), .depth(depth)) u_tx_fifo (
        .clk   (g_clk),
        .rst   (g_clr),
        .push  (tx_push),
        .pop   (tx_ready & ~tx_empty_int),
        .wdata (p_bus_out),
        .rdata (tx_data),
        .count (tx_count),
        .empty (tx_empty_int),
        .full  (tx_full_int)
    );

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state_reg  <= IDLE;
            dir_reg    <= DIR_RD;
            bus_in_reg <= '0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            if (load_bus) begin
                bus_in_reg <= rx_head;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        load_bus   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (p_hs_out && p_wr_nrd && tx_room) begin
                    tx_push    = 1'b1;
                    dir_next   = DIR_WR;
                    state_next = ACK;
                end else if (p_hs_out && !p_wr_nrd && rx_avail) begin
                    load_bus   = 1'b1;
                    dir_next   = DIR_RD;
                    state_next = ACK;
                end
            end
            ACK: begin
                // The RX entry is consumed only once the processor has let go.
                if (!p_hs_out) begin
                    rx_pop     = (dir_reg == DIR_RD);
                    state_next = REL;
                end
            end
            REL:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign p_hs_in  = (state_reg == ACK);
    assign p_bus_in = bus_in_reg;
    assign rx_ready = ~rx_full_int;
    assign rx_empty = rx_empty_int;
    assign tx_valid = ~tx_empty_int;
    assign tx_full  = tx_full_int;

endmodule

// File: tb/tb_io_handshake_port.sv
// Scenario bench for io_handshake_port: directed protocol cases plus a
// randomized read stream checked against a queue model of the RX buffer.
module tb_io_handshake_port;

    logic       g_clk = 1'b0;
    logic       g_clr = 1'b1;
    logic       p_hs_out = 1'b0;
    logic       p_wr_nrd = 1'b0;
    logic [7:0] p_bus_out = 8'h00;
    logic [7:0] p_bus_in;
    logic       p_hs_in;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       rx_empty;
    logic       tx_full;

    int checks = 0;
    int failures = 0;

    io_handshake_port #(.width(8), .depth(4)) dut (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .p_hs_out  (p_hs_out),
        .p_wr_nrd  (p_wr_nrd),
        .p_bus_out (p_bus_out),
        .p_bus_in  (p_bus_in),
        .p_hs_in   (p_hs_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_empty  (rx_empty),
        .tx_full   (tx_full)
    );

    always #5 g_clk = ~g_clk;

    task automatic cycle();
        @(posedge g_clk);
        #1;
    endtask

    // One complete processor transfer; reports timeout instead of hanging.
    task automatic do_xfer(input logic wr, input logic [7:0] wdata,
                           output logic [7:0] rdata, output bit timeout);
        timeout = 1'b1;
        p_wr_nrd  = wr;
        p_bus_out = wdata;
        p_hs_out  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (p_hs_in === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        rdata = p_bus_in;
        p_hs_out = 1'b0;
        cycle();
        cycle();
        $display("xfer %s data=%02h timeout=%0d", wr ? "wr" : "rd", wr ? wdata : rdata, timeout);
    endtask

    task automatic test_reset();
        g_clr = 1'b1;
        cycle();
        cycle();
        g_clr = 1'b0;
        cycle();
        checks++; if (p_hs_in !== 1'b0) begin failures++; $display("FAIL reset_hs_in got=%b exp=0", p_hs_in); end
        checks++; if (p_bus_in !== 8'h00) begin failures++; $display("FAIL reset_bus_in got=%h exp=00", p_bus_in); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); end
        checks++; if (tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
        $display("reset done");
    endtask

    task automatic test_read_path();
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        checks++; if (rx_empty !== 1'b0) begin failures++; $display("FAIL rd_rx_empty_after_push got=%b exp=0", rx_empty); end
        p_wr_nrd = 1'b0;
        p_hs_out = 1'b1;
        cycle();
        checks++; if (p_hs_in !== 1'b1) begin failures++; $display("FAIL rd_ack got=%b exp=1", p_hs_in); end
        checks++; if (p_bus_in !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", p_bus_in); end
        p_hs_out = 1'b0;
        cycle();
        checks++; if (p_hs_in !== 1'b0) begin failures++; $display("FAIL rd_ack_fall got=%b exp=0", p_hs_in); end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL rd_rx_empty_after_pop got=%b exp=1", rx_empty); end
        cycle();
        checks++; if (p_bus_in !== 8'hA5) begin failures++; $display("FAIL rd_data_hold got=%h exp=a5", p_bus_in); end
        $display("read path A5 done");
    endtask

    task automatic test_write_stall();
        logic [7:0] rd;
        bit         to;
        logic [7:0] exp_tx [4] = '{8'h02, 8'h03, 8'h04, 8'h05};
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            do_xfer(1'b1, 8'(i), rd, to);
            checks++; if (to) begin failures++; $display("FAIL wr_ack_timeout idx=%0d got=timeout exp=ack", i); end
        end
        checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL wr_tx_full got=%b exp=1", tx_full); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin failures++; $display("FAIL wr_head got=%b/%h exp=1/01", tx_valid, tx_data); end
        p_wr_nrd = 1'b1;
        p_bus_out = 8'h05;
        p_hs_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (p_hs_in !== 1'b0) begin failures++; $display("FAIL wr_full_stall cyc=%0d got=%b exp=0", i, p_hs_in); end
        end
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        checks++; if (p_hs_in !== 1'b0) begin failures++; $display("FAIL wr_stall_on_pop_edge got=%b exp=0", p_hs_in); end
        checks++; if (tx_data !== 8'h02) begin failures++; $display("FAIL wr_head_after_pop got=%h exp=02", tx_data); end
        cycle();
        checks++; if (p_hs_in !== 1'b1) begin failures++; $display("FAIL wr_fifth_ack got=%b exp=1", p_hs_in); end
        p_hs_out = 1'b0;
        cycle();
        cycle();
        $display("xfer wr data=05 (after stall)");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_tx[i]) begin
                failures++;
                $display("FAIL wr_drain idx=%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_tx[i]);
            end
            cycle();
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL wr_drained got=%b exp=0", tx_valid); end
    endtask

    task automatic test_rx_full();
        logic [7:0] rd;
        bit         to;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(8'h10 + i);
            checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL full_ready_fill idx=%0d got=%b exp=1", i, rx_ready); end
            cycle();
        end
        rx_data = 8'h14;
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low got=%b exp=0", rx_ready); end
        cycle();
        p_wr_nrd = 1'b0;
        p_hs_out = 1'b1;
        cycle();
        checks++; if (p_hs_in !== 1'b1 || p_bus_in !== 8'h10) begin failures++; $display("FAIL full_first_read got=%b/%h exp=1/10", p_hs_in, p_bus_in); end
        p_hs_out = 1'b0;
        cycle();
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", rx_ready); end
        cycle();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL full_ready_refill got=%b exp=0", rx_ready); end
        $display("xfer rd data=10 (from full fifo)");
        for (int i = 1; i <= 4; i++) begin
            do_xfer(1'b0, 8'h00, rd, to);
            checks++;
            if (to || rd !== 8'(8'h10 + i)) begin
                failures++;
                $display("FAIL full_order idx=%0d got=%h to=%0d exp=%h", i, rd, to, 8'(8'h10 + i));
            end
        end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL full_empty_end got=%b exp=1", rx_empty); end
    endtask

    task automatic test_read_empty();
        p_wr_nrd = 1'b0;
        p_hs_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (p_hs_in !== 1'b0) begin failures++; $display("FAIL empty_stall cyc=%0d got=%b exp=0", i, p_hs_in); end
        end
        rx_data = 8'h3C;
        rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        checks++; if (p_hs_in !== 1'b0 || rx_empty !== 1'b0) begin failures++; $display("FAIL empty_push_edge got=hs%b/empty%b exp=0/0", p_hs_in, rx_empty); end
        cycle();
        checks++; if (p_hs_in !== 1'b1 || p_bus_in !== 8'h3C) begin failures++; $display("FAIL empty_late_ack got=%b/%h exp=1/3c", p_hs_in, p_bus_in); end
        p_hs_out = 1'b0;
        cycle();
        cycle();
        $display("xfer rd data=3c (after empty stall)");
    endtask

    task automatic test_wrap_random();
        logic [7:0] q [$];
        logic [7:0] d;
        int         reads = 0;
        int         phase = 0;
        int         waited = 0;
        bit         push, pop;
        p_wr_nrd = 1'b0;
        for (int cyc = 0; cyc < 600 && reads < 10; cyc++) begin
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            d = rx_data;
            checks++;
            if (rx_ready !== ((q.size() < 4) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL wrap_rx_ready cyc=%0d got=%b exp_size=%0d", cyc, rx_ready, q.size());
            end
            push = rx_valid && (q.size() < 4);
            pop = 1'b0;
            case (phase)
                0: begin
                    p_hs_out = 1'b1;
                    phase = 1;
                    waited = 0;
                end
                1: begin
                    if (p_hs_in === 1'b1) begin
                        checks++;
                        if (q.size() == 0 || p_bus_in !== q[0]) begin
                            failures++;
                            $display("FAIL wrap_data read=%0d got=%h exp=%h", reads, p_bus_in, (q.size() != 0) ? q[0] : 8'hxx);
                        end
                        if ($urandom_range(0, 1) == 0) begin
                            $display("xfer rd data=%02h (wrap %0d)", p_bus_in, reads);
                            p_hs_out = 1'b0;
                            pop = 1'b1;
                            phase = 2;
                            reads++;
                        end
                    end else begin
                        waited++;
                        if (waited > 50) begin
                            checks++;
                            failures++;
                            $display("FAIL wrap_ack_timeout read=%0d got=no_ack exp=ack", reads);
                            break;
                        end
                    end
                end
                2: phase = 3;
                default: phase = 0;
            endcase
            cycle();
            if (pop && q.size() != 0) void'(q.pop_front());
            if (push) q.push_back(d);
            checks++;
            if (rx_empty !== ((q.size() == 0) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL wrap_rx_empty cyc=%0d got=%b exp_size=%0d", cyc, rx_empty, q.size());
            end
            if (phase == 2) begin
                checks++;
                if (p_hs_in !== 1'b0) begin failures++; $display("FAIL wrap_ack_fall cyc=%0d got=%b exp=0", cyc, p_hs_in); end
            end
        end
        rx_valid = 1'b0;
        p_hs_out = 1'b0;
        checks++; if (reads != 10) begin failures++; $display("FAIL wrap_read_count got=%0d exp=10", reads); end
        cycle();
        cycle();
    endtask

    task automatic test_reset_during_ack();
        logic [7:0] rd;
        bit         to;
        tx_ready = 1'b0;
        do_xfer(1'b1, 8'h77, rd, to);
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_tx_valid got=%b exp=1", tx_valid); end
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        cycle();
        rx_data = 8'h6B;
        cycle();
        rx_valid = 1'b0;
        p_wr_nrd = 1'b0;
        p_hs_out = 1'b1;
        cycle();
        checks++; if (p_hs_in !== 1'b1) begin failures++; $display("FAIL rst_pre_ack got=%b exp=1", p_hs_in); end
        #2;
        g_clr = 1'b1;
        #1;
        checks++; if (p_hs_in !== 1'b0) begin failures++; $display("FAIL rst_async_hs_in got=%b exp=0", p_hs_in); end
        checks++; if (p_bus_in !== 8'h00) begin failures++; $display("FAIL rst_async_bus_in got=%h exp=00", p_bus_in); end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL rst_async_rx_empty got=%b exp=1", rx_empty); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_async_tx_valid got=%b exp=0", tx_valid); end
        p_hs_out = 1'b0;
        @(negedge g_clk);
        g_clr = 1'b0;
        cycle();
        checks++; if (p_hs_in !== 1'b0) begin failures++; $display("FAIL rst_release_hs_in got=%b exp=0", p_hs_in); end
        $display("reset during ack done");
    endtask

    initial begin
        test_reset();
        test_read_path();
        test_write_stall();
        test_rx_full();
        test_read_empty();
        test_wrap_random();
        test_reset_during_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
